// File: rtl/time_pkt_pkg.sv
// Shared constants, FSM encoding and byte-builder helpers for the time event packer.
// The two-byte packet layout is defined here so the top and any host-side model agree.
package time_pkt_pkg;

    localparam int TIME_W   = 11;

    localparam int HDR_BIT  = 7;
    localparam int LOST_BIT = 6;
    localparam int OVF_BIT  = 5;

    // Interval split between the header and the low byte.
    localparam int HI_MSB   = 9;
    localparam int HI_LSB   = 5;
    localparam int LO_MSB   = 4;
    localparam int LO_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        LOW
    } pk_state_t;

    typedef struct packed {
        logic              lost;
        logic [TIME_W-1:0] word;
    } pkt_hold_t;

    function automatic logic [7:0] hdr_byte(input pkt_hold_t p);
        logic [7:0] b;
        b                        = '0;
        b[HDR_BIT]               = 1'b1;
        b[LOST_BIT]              = p.lost;
        b[OVF_BIT]               = p.word[TIME_W-1];
        b[HI_MSB-HI_LSB:0]       = p.word[HI_MSB:HI_LSB];
        return b;
    endfunction

    function automatic logic [7:0] lo_byte(input pkt_hold_t p);
        logic [7:0] b;
        b                        = '0;
        b[LO_MSB-LO_LSB:0]       = p.word[LO_MSB:LO_LSB];
        return b;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Single-clock first-word-fall-through FIFO with an explicit occupancy count.
// Pushes while full and pops while empty are ignored.
module event_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/time_event_packer.sv
// Captures a time word on each rising edge of to_fifo, buffers it, and serialises
// it as a header/low byte pair on a valid/ready stream, flagging buffer-full drops.
module time_event_packer
    import time_pkt_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TIME_W = 11
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [TIME_W-1:0]        time_in,
    input  logic                     to_fifo,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               drop_count
);

    pk_state_t         state;
    pk_state_t         next_state;
    pkt_hold_t         hold;

    logic              to_fifo_d;
    logic              wr_req;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;
    logic              lost_pending;
    logic [TIME_W-1:0] fifo_dout;

    // Fullness is the registered level, so a same-cycle pop cannot rescue a write.
    assign wr_req    = to_fifo && !to_fifo_d;
    assign drop      = wr_req && fifo_full;
    assign fifo_push = wr_req && !fifo_full;

    event_fifo #(
        .WIDTH (TIME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (time_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Reset to 1 so a strobe already high at reset release is not an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            to_fifo_d <= 1'b1;
        else
            to_fifo_d <= to_fifo;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            drop_count <= '0;
        else if (drop && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
    end

    // A drop coinciding with a pop stays pending for the following packet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            lost_pending <= 1'b0;
        else if (drop)
            lost_pending <= 1'b1;
        else if (fifo_pop)
            lost_pending <= 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold <= '0;
        end else if (fifo_pop) begin
            hold.lost <= lost_pending;
            hold.word <= fifo_dout;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        byte_valid = 1'b0;
        byte_out   = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    next_state = HDR;
                end
            end
            HDR: begin
                byte_valid = 1'b1;
                byte_out   = hdr_byte(hold);
                if (byte_ready)
                    next_state = LOW;
            end
            LOW: begin
                byte_valid = 1'b1;
                byte_out   = lo_byte(hold);
                if (byte_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        next_state = HDR;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
